// File: rtl/rmt_pkg.sv
// Shared RMT pipeline constants: default PHV/VLAN widths and the PHV container
// layout used by key extraction, action stages and the inter-stage links.
package rmt_pkg;

    localparam int PHV_LEN        = 1024;
    localparam int C_VLANID_WIDTH = 12;

    // PHV layout, LSB first: 256-bit metadata, then 8x16b, 8x32b, 8x48b containers
    localparam int PHV_META_W   = 256;
    localparam int PHV_CNT_PER  = 8;
    localparam int PHV_OFF_META = 0;
    localparam int PHV_OFF_16   = PHV_OFF_META + PHV_META_W;
    localparam int PHV_OFF_32   = PHV_OFF_16 + PHV_CNT_PER * 16;
    localparam int PHV_OFF_48   = PHV_OFF_32 + PHV_CNT_PER * 32;

    typedef enum logic [1:0] {
        CONT_16 = 2'd0,
        CONT_32 = 2'd1,
        CONT_48 = 2'd2
    } container_e;

    function automatic int phv_container_lsb(input container_e kind, input int idx);
        case (kind)
            CONT_16: return PHV_OFF_16 + idx * 16;
            CONT_32: return PHV_OFF_32 + idx * 32;
            default: return PHV_OFF_48 + idx * 48;
        endcase
    endfunction

endpackage

// File: rtl/phv_stage_link_if.sv
// Stage-to-stage link bundle: stage N push side and stage N+1 pull side.
interface phv_stage_link_if #(
    parameter int PHV_LEN = rmt_pkg::PHV_LEN,
    parameter int VLAN_W  = rmt_pkg::C_VLANID_WIDTH
);

    logic [PHV_LEN-1:0] phv_in;
    logic               phv_in_valid;
    logic               phv_in_ready;
    logic [VLAN_W-1:0]  vlan_in;
    logic               vlan_valid_in;
    logic               vlan_in_ready;

    logic [PHV_LEN-1:0] phv_out;
    logic               phv_out_valid;
    logic               phv_out_ready;
    logic [VLAN_W-1:0]  vlan_out;
    logic               vlan_valid_out;
    logic               vlan_out_ready;

    // The link receives on slave and drives downstream on master
    modport slave (
        input  phv_in, phv_in_valid, vlan_in, vlan_valid_in,
        output phv_in_ready, vlan_in_ready
    );

    modport master (
        output phv_out, phv_out_valid, vlan_out, vlan_valid_out,
        input  phv_out_ready, vlan_out_ready
    );

endinterface

// File: rtl/link_fifo.sv
// Small synchronous FIFO; storage is registered so the head is visible the
// cycle after it is written, and everything clears on reset.
module link_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 2
) (
    input  logic                  axis_clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   count
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH; storage is cleared so outputs read 0 after reset
    always_ff @(posedge axis_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{DEPTH_BITS{1'b0}}, do_wr} - {{DEPTH_BITS{1'b0}}, do_rd};
        end
    end

endmodule

// File: rtl/phv_stage_link.sv
// Elastic PHV/VLAN link between match-action stages; a PHV is only released
// once its VLAN token has already been forwarded downstream.
module phv_stage_link #(
    parameter int PHV_LEN         = rmt_pkg::PHV_LEN,
    parameter int C_VLANID_WIDTH  = rmt_pkg::C_VLANID_WIDTH,
    parameter int PHV_DEPTH_BITS  = 2,
    parameter int VLAN_DEPTH_BITS = 2,
    parameter int LEAD_W          = 4
) (
    input  logic                    axis_clk,
    input  logic                    reset,
    phv_stage_link_if.slave         up,
    phv_stage_link_if.master        dn,
    output logic                    vlan_overflow,
    output logic [PHV_DEPTH_BITS:0] phv_count
);

    localparam logic [VLAN_DEPTH_BITS:0] VLAN_FULL_COUNT =
        (VLAN_DEPTH_BITS + 1)'(1 << VLAN_DEPTH_BITS);
    localparam logic [LEAD_W-1:0] LEAD_MAX = '1;

    logic                     phv_full;
    logic                     phv_empty;
    logic                     vlan_full;
    logic                     vlan_empty;
    logic [VLAN_DEPTH_BITS:0] vlan_count;
    logic                     phv_fire;
    logic                     vlan_fire;
    logic [LEAD_W-1:0]        lead;

    // Input readies depend only on registered occupancy, never on downstream ready
    assign up.phv_in_ready  = !phv_full && !reset;
    assign up.vlan_in_ready = (vlan_count != VLAN_FULL_COUNT) && !reset;

    assign dn.vlan_valid_out = !vlan_empty && (lead != LEAD_MAX);
    assign dn.phv_out_valid  = !phv_empty && (lead != '0);

    assign vlan_fire = dn.vlan_valid_out && dn.vlan_out_ready;
    assign phv_fire  = dn.phv_out_valid && dn.phv_out_ready;

    link_fifo #(
        .WIDTH      (PHV_LEN),
        .DEPTH_BITS (PHV_DEPTH_BITS)
    ) u_phv_fifo (
        .axis_clk (axis_clk),
        .reset    (reset),
        .wr_en    (up.phv_in_valid && up.phv_in_ready),
        .wr_data  (up.phv_in),
        .rd_en    (phv_fire),
        .rd_data  (dn.phv_out),
        .full     (phv_full),
        .empty    (phv_empty),
        .count    (phv_count)
    );

    link_fifo #(
        .WIDTH      (C_VLANID_WIDTH),
        .DEPTH_BITS (VLAN_DEPTH_BITS)
    ) u_vlan_fifo (
        .axis_clk (axis_clk),
        .reset    (reset),
        .wr_en    (up.vlan_valid_in && up.vlan_in_ready),
        .wr_data  (up.vlan_in),
        .rd_en    (vlan_fire),
        .rd_data  (dn.vlan_out),
        .full     (vlan_full),
        .empty    (vlan_empty),
        .count    (vlan_count)
    );

    // lead = tokens forwarded minus PHVs forwarded; the valid gating keeps it in range
    always_ff @(posedge axis_clk) begin
        if (reset) begin
            lead <= '0;
        end else if (vlan_fire && !phv_fire) begin
            lead <= lead + 1'b1;
        end else if (phv_fire && !vlan_fire) begin
            lead <= lead - 1'b1;
        end
    end

    // The VLAN path is push-only upstream, so a push into a full buffer is lost for good
    always_ff @(posedge axis_clk) begin
        if (reset) begin
            vlan_overflow <= 1'b0;
        end else if (up.vlan_valid_in && vlan_full) begin
            vlan_overflow <= 1'b1;
        end
    end

endmodule

// File: doc/phv_stage_link.md
# phv_stage_link

Elastic link between two consecutive match-action stages. It buffers PHVs and VLAN-ID tokens from stage N and presents them to stage N+1 with independent ready/valid handshakes. It guarantees that packet k's VLAN token is delivered downstream strictly before packet k's PHV, so the downstream key extractor never pops an empty VLAN FIFO. It also provides backpressure and a sticky overflow flag for the push-style VLAN path.

## Interface
- PHV_LEN, 1024, PHV width (48*8+32*8+16*8+256)
- C_VLANID_WIDTH, 12, VLAN token width
- PHV_DEPTH_BITS, 2, log2 of PHV buffer depth (4 entries)
- VLAN_DEPTH_BITS, 2, log2 of VLAN buffer depth (4 entries)
- LEAD_W, 4, width of VLAN-lead counter
- axis_clk  in  1  clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- phv_in  in  PHV_LEN  PHV from stage N
- phv_in_valid  in  1  PHV strobe
- phv_in_ready  out  1  space available (drives stage N stage_ready_in)
- vlan_in  in  C_VLANID_WIDTH  VLAN token from stage N
- vlan_valid_in  in  1  push strobe; no ready honoured upstream
- vlan_in_ready  out  1  VLAN buffer not full
- phv_out  out  PHV_LEN  PHV to stage N+1
- phv_out_valid  out  1  PHV available
- phv_out_ready  in  1  stage N+1 stage_ready_out
- vlan_out  out  C_VLANID_WIDTH  token to stage N+1
- vlan_valid_out  out  1  token available
- vlan_out_ready  in  1  stage N+1 vlan_fifo_ready
- vlan_overflow  out  1  sticky: push while VLAN buffer full
- phv_count  out  PHV_DEPTH_BITS+1  PHV buffer occupancy

## Operation
- PHV buffer: FIFO of 2^PHV_DEPTH_BITS entries. Write when phv_in_valid && phv_in_ready. phv_in_ready = (phv_count != 2^PHV_DEPTH_BITS) && !reset.
- VLAN buffer: FIFO of 2^VLAN_DEPTH_BITS entries. Write when vlan_valid_in && vlan_in_ready.
- vlan_valid_in while full: token dropped, vlan_overflow set to 1. It stays 1 until reset.
- VLAN fire = vlan_valid_out && vlan_out_ready. PHV fire = phv_out_valid && phv_out_ready.
- lead counter (LEAD_W bits, unsigned) = tokens forwarded minus PHVs forwarded.
  - +1 on VLAN fire only; -1 on PHV fire only; unchanged on both or neither.
- vlan_valid_out = VLAN buffer non-empty && lead != 2^LEAD_W-1. lead never wraps.
- phv_out_valid = PHV buffer non-empty && lead != 0, using the registered lead. A PHV is never released in the same cycle its token fires.
- Simultaneous write and read on a full PHV buffer: not possible, because ready is low when full. Simultaneous write and read on a non-full buffer: occupancy unchanged.
- Pointers wrap modulo depth. Occupancy uses one extra bit.
- phv_out and vlan_out are undefined-but-stable while their valid is low. The bench checks data only when valid is high.

## Timing
- Reset values: phv_out_valid=0, vlan_valid_out=0, vlan_overflow=0, phv_count=0, phv_in_ready=0, vlan_in_ready=0, phv_out=0, vlan_out=0, lead=0.
- The first cycle after reset deasserts: both ready outputs are 1.
- Reset mid-operation: both buffers flush and lead clears. In-flight data is lost; no partial output.
- Latency, VLAN: token written in cycle t is visible with vlan_valid_out in t+1 (registered FIFO head).
- Latency, PHV: a PHV written in cycle t is visible in t+1 if lead>0 at t+1. Otherwise it appears one cycle after the enabling VLAN fire.
- Minimum empty-link latency for a packet whose token and PHV arrive together at t:
  - token out at t+1;
  - PHV out at t+2.
- Throughput: one PHV per cycle in steady state once lead ≥ 1.
- phv_in_ready and vlan_in_ready are derived from registered occupancy only. They have no combinational path from any output-side ready.

## Structure
- Shared package rmt_pkg holds:
  - PHV_LEN and C_VLANID_WIDTH defaults;
  - the PHV field-offset constants shared with key extraction and action stages.
- One sub-module, link_fifo: synchronous FIFO with registered head and full/empty/count. It is instantiated twice (PHV width, VLAN width).
- Lead counter, overflow flag and gating logic live in phv_stage_link.

## Test plan
- Token 0x00A and PHV P0 both presented at cycle 5, downstream always ready -> vlan_out=0x00A valid at 6, phv_out=P0 valid at 7, lead back to 0 at 8.
- PHVs P0..P3 pushed, no tokens -> phv_count=4, phv_in_ready=0, phv_out_valid stays 0. Then tokens 1,2,3,4 -> outputs P0..P3 in order, each PHV strictly after its token.
- 5 tokens pushed back-to-back, vlan_out_ready=0 -> 4 buffered, vlan_in_ready=0 at the 5th, vlan_overflow=1 and stays 1; release -> tokens 1..4 in order.
- phv_out_ready toggling 1/0 every cycle with continuous matched input -> no loss, no duplication, order preserved, phv_count never exceeds 4.
- Reset asserted for 1 cycle with 3 PHVs and 2 tokens buffered -> next cycle: all valids 0, phv_count=0, lead=0, vlan_overflow=0, readies 1.
- Lead saturation: 15 tokens forwarded with no PHVs -> vlan_valid_out held 0 with the 16th token buffered; one PHV fire -> the token forwards the following cycle.
